// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment display path.
//   NUM_DIGITS   - digits on the board display
//   BLANK_NIBBLE - nibble value rendered as a dark digit (also used by the
//                  BCD stage to fill unused leading digits)
//   SEG_CODE     - nibble -> {g,f,e,d,c,b,a}, active-high, indexed by nibble
package seg7_pkg;

   localparam int         NUM_DIGITS   = 8;
   localparam logic [3:0] BLANK_NIBBLE = 4'hF;

   // Element 15 is listed first (packed array, MSB first).
   localparam logic [15:0][6:0] SEG_CODE = {
      7'h00,   // F : blank
      7'h79,   // E
      7'h5E,   // d
      7'h39,   // C
      7'h7C,   // b
      7'h77,   // A
      7'h6F,   // 9
      7'h7F,   // 8
      7'h07,   // 7
      7'h7D,   // 6
      7'h6D,   // 5
      7'h66,   // 4
      7'h4F,   // 3
      7'h5B,   // 2
      7'h06,   // 1
      7'h3F    // 0
   };

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble to seven-segment decoder, active-high.
//   nibble_i - 4-bit digit value (0-9, A-E, F = blank)
//   seg_o    - {g,f,e,d,c,b,a}, 1 = segment lit
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_CODE[nibble_i];

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for an 8-digit seven-segment display.
//   clk        - system clock
//   rst        - synchronous active-high reset
//   disp_data  - packed nibbles, [3:0] = rightmost digit ... [31:28] = leftmost
//   dp_mask    - decimal point request, bit i = digit i
//   an         - anode enables, bit i = digit i
//   seg        - {g,f,e,d,c,b,a}
//   dp         - decimal point
//   frame_sync - one-cycle pulse when a new frame's data has been latched
// Display data is captured only at the frame boundary so a frame never mixes
// old and new digits. All outputs are registered (one cycle of latency).
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV     = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] disp_data,
   input  logic [7:0]  dp_mask,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_sync
);

   localparam int             CW        = $clog2(SCAN_DIV);
   localparam logic [CW-1:0]  CNT_MAX   = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]  BLANK_LIM = CW'(BLANK_CYCLES);

   // Polarity masks: XOR with these turns an active-high value into the
   // pin level, and also gives the "everything off" level when applied to 0.
   localparam logic [7:0] AN_POL  = {8{ACTIVE_LOW}};
   localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
   localparam logic       DP_POL  = ACTIVE_LOW;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   shadow_data_q;
   logic [7:0]    shadow_dp_q;
   logic          frame_sync_q;
   logic [7:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          last_slot;
   logic          boundary;
   logic          in_blank;
   logic [3:0]    cur_nibble;
   logic [6:0]    cur_seg;

   // Anti-ghost window at the start of each slot; a zero-length window is
   // removed entirely rather than compared against zero.
   generate
      if (BLANK_CYCLES > 0) begin : g_blank
         assign in_blank = (cnt_q < BLANK_LIM);
      end else begin : g_noblank
         assign in_blank = 1'b0;
      end
   endgenerate

   assign last_slot  = (cnt_q == CNT_MAX);
   assign boundary   = last_slot && (idx_q == 3'(NUM_DIGITS - 1));
   assign cur_nibble = shadow_data_q[idx_q*4 +: 4];

   seg7_decode u_decode (
      .nibble_i (cur_nibble),
      .seg_o    (cur_seg)
   );

   always_comb begin
      cnt_d = last_slot ? '0 : cnt_q + 1'b1;
      idx_d = last_slot ? idx_q + 3'd1 : idx_q;

      an_d  = '0;
      seg_d = '0;
      dp_d  = 1'b0;
      if (!in_blank) begin
         an_d  = 8'd1 << idx_q;
         seg_d = cur_seg;
         dp_d  = shadow_dp_q[idx_q];
      end
      an_d  = an_d  ^ AN_POL;
      seg_d = seg_d ^ SEG_POL;
      dp_d  = dp_d  ^ DP_POL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         shadow_data_q <= {NUM_DIGITS{BLANK_NIBBLE}};
         shadow_dp_q   <= '0;
         frame_sync_q  <= 1'b0;
         an_q          <= AN_POL;
         seg_q         <= SEG_POL;
         dp_q          <= DP_POL;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         frame_sync_q <= boundary;
         if (boundary) begin
            shadow_data_q <= disp_data;
            shadow_dp_q   <= dp_mask;
         end
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_sync = frame_sync_q;

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
Time-multiplexed driver for the board's 8-digit common-anode seven-segment display. It consumes the 32-bit packed display word produced by the frequency-to-BCD stage: 8 nibbles, nibble 0 is the rightmost digit, and nibble 0xF means blank. It scans one digit at a time, decodes the nibble to segments and drives anodes, segments and the decimal point. Display data is latched once per frame so a displayed frame never mixes old and new digits.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range >= 2
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 <= BLANK_CYCLES < SCAN_DIV
ACTIVE_LOW, 1, 1 = an/seg/dp outputs are active-low; 0 = active-high

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
disp_data  in  32  packed nibbles; [3:0] = digit 0 (rightmost) ... [31:28] = digit 7
dp_mask  in  8  decimal point request per digit, bit i = digit i
an  out  8  anode enables, bit i = digit i
seg  out  7  {g,f,e,d,c,b,a}
dp  out  1  decimal point
frame_sync  out  1  one-cycle pulse when a new frame's data is latched

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous, active-high.
- Reset state: cnt=0, idx=0, shadow_data=32'hFFFF_FFFF, shadow_dp=8'h00, frame_sync=0.
- Outputs during reset: all outputs in the "off" state in the cycle after rst is sampled high. With ACTIVE_LOW=1 that is an=8'hFF, seg=7'h7F, dp=1.
- Slot counter: cnt increments every clk. When cnt==SCAN_DIV-1, cnt wraps to 0 and idx increments, wrapping from 7 to 0.
- Frame boundary: the clk edge where cnt==SCAN_DIV-1 and idx==7. At that edge:
  - shadow_data<=disp_data and shadow_dp<=dp_mask.
  - frame_sync<=1 for exactly that one cycle, then 0.
  - Between boundaries, disp_data and dp_mask changes are ignored.
- Output registers update every clk from the current (cnt, idx, shadow) values, giving one cycle of latency.
  - If cnt < BLANK_CYCLES: all anodes, segments and dp are off.
  - Otherwise: an has only bit idx asserted; seg = decode(shadow_data[4*idx+3:4*idx]); dp = shadow_dp[idx].
- Decode table, active-high before polarity:
  - Digits: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Hex letters: A=77, b=7C, C=39, d=5E, E=79.
  - F=00 (blank).
- Blank digits: the anode is still asserted and the segments are dark. dp is still honoured on blank digits.
- Polarity: when ACTIVE_LOW=1, an, seg and dp are bitwise inverted at the output register input.
- Reset mid-operation: rst has priority over counter advance and over frame-boundary capture. The first frame after reset displays all blank. Live data appears after the first frame boundary, 8*SCAN_DIV cycles after reset release.
- Arithmetic: cnt width is $clog2(SCAN_DIV); idx is 3 bits with natural wrap. No other arithmetic.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry segment code constants;
  - the blank nibble constant 4'hF, shared with the BCD stage's unused-digit fill;
  - the digit count 8.
- Sub-module seg7_decode: combinational 4-bit nibble to 7-bit segment, active-high. It is reusable by other display paths.
- seg7_scan holds the counters, shadow registers, output registers and polarity inversion.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1 unless stated):
1. Reset: hold rst 3 cycles, then release -> an=FF, seg=7F, dp=1, frame_sync=0 during reset. All digits stay dark for the first 32 cycles.
2. disp_data=32'hFFFF_1234, dp_mask=0 -> frame_sync pulses at cycle 31 after release. In the next frame, digit0 slot shows an=FE, seg=~66=19; digit3 shows an=F7, seg=~06=79; digits 4-7 show seg=7F.
3. Frame coherence: change disp_data from FFFF_1234 to FFFF_5678 at mid-frame (idx=2) -> digits 2-7 of the current frame still show the old values. The new value appears only after the next frame_sync.
4. Anti-ghost: in every slot, the output at cycle offset 1 (cnt==0 registered) is an=FF. Offsets 2-4 show the single active anode. Repeat with BLANK_CYCLES=0: no blank cycle.
5. Reset mid-frame: assert rst at idx=5, cnt=2 -> outputs off on the next cycle. After release, idx restarts at 0 and the display is blank until the next boundary.
6. Hex/dp with ACTIVE_LOW=0: disp_data=32'hEDCB_A987, dp_mask=8'h81 -> digit7 shows seg=79, dp=1; digit0 shows seg=07, dp=1; digit4 shows seg=77, dp=0.
